affine_interp_sched: RTL and testbench

Sequencer for the 8-tap affine interpolation filter bank. Accepts one fractional-position command. Streams the 8 reference samples one per cycle through the shared per-tap MCM bank, selecting the product for the commanded 1/16 position. Accumulates the products, rounds and normalises the sum, and returns one interpolated 8-bit sample through a valid/ready handshake. It sits between the reference-sample fetch and the prediction buffer.

---
 rtl/affine_interp_pkg.sv | 17 +
 rtl/affine_round_clip.sv | 36 +++
 rtl/affine_interp_sched.sv | 120 ++++++++++++
 tb/tb_affine_interp_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/affine_interp_pkg.sv
// rtl/affine_interp_pkg.sv - shared widths, constants and FSM states for the affine interpolation sequencer
package affine_interp_pkg;
    localparam int SAMPLE_W    = 8;
    localparam int ACC_W       = 16;
    localparam int NTAPS       = 8;
    localparam int SHIFT       = 6;
    localparam int CENTER_TAP  = 3;
    localparam int FRAC_W      = 4;
    localparam int TAP_W       = $clog2(NTAPS);
    localparam int ROUND_CONST = 1 << (SHIFT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/affine_round_clip.sv
// rtl/affine_round_clip.sv - add-round, arithmetic normalise shift, optional saturation (AFFINE_CLIP_EN)
module affine_round_clip
    import affine_interp_pkg::*;
(
    input  logic [ACC_W-1:0]    sum_i,
    output logic [SAMPLE_W-1:0] res_o
);
    localparam logic signed [ACC_W:0] RC = ROUND_CONST;

    logic signed [ACC_W:0]       biased;
    logic signed [ACC_W-SHIFT:0] shifted;
    logic                        unused_bits;

    // one guard bit keeps the rounding add from wrapping near the positive limit
    assign biased  = $signed({sum_i[ACC_W-1], sum_i}) + RC;
    assign shifted = $signed(biased[ACC_W:SHIFT]);

`ifdef AFFINE_CLIP_EN
    localparam logic signed [ACC_W-SHIFT:0] MAXV = (1 <<< (SAMPLE_W - 1)) - 1;
    localparam logic signed [ACC_W-SHIFT:0] MINV = -(1 <<< (SAMPLE_W - 1));

    assign unused_bits = ^biased[SHIFT-1:0];

    always_comb begin
        res_o = shifted[SAMPLE_W-1:0];
        if (shifted > MAXV) begin
            res_o = MAXV[SAMPLE_W-1:0];
        end else if (shifted < MINV) begin
            res_o = MINV[SAMPLE_W-1:0];
        end
    end
`else
    assign unused_bits = ^{biased[SHIFT-1:0], shifted[ACC_W-SHIFT:SAMPLE_W]};
    assign res_o       = shifted[SAMPLE_W-1:0];
`endif
endmodule

// File: rtl/affine_interp_sched.sv
// rtl/affine_interp_sched.sv - 8-tap affine interpolation sequencer; AFFINE_CLIP_EN selects saturating output
module affine_interp_sched
    import affine_interp_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [FRAC_W-1:0]   cfg_frac,
    input  logic                smp_valid,
    output logic                smp_ready,
    input  logic [SAMPLE_W-1:0] smp_data,
    output logic [TAP_W-1:0]    mcm_tap,
    output logic [FRAC_W-1:0]   mcm_frac,
    output logic [SAMPLE_W-1:0] mcm_x,
    input  logic [ACC_W-1:0]    mcm_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] out_data,
    output logic                busy
);
    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [SAMPLE_W-1:0] ctr_q, ctr_d;
    logic [SAMPLE_W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [ACC_W-1:0]    acc_sum;
    logic [SAMPLE_W-1:0] rounded;
    logic                cfg_hs, smp_hs;

    assign cfg_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign smp_ready = (state_q == ACC);
    assign busy      = (state_q != IDLE);
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign smp_hs    = smp_valid && smp_ready;

    assign mcm_x     = smp_data;
    assign mcm_tap   = tap_q;
    assign mcm_frac  = frac_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // last tap folds its product in combinationally so DONE follows immediately
    assign acc_sum = acc_q + mcm_y;

    affine_round_clip u_round_clip (
        .sum_i (acc_sum),
        .res_o (rounded)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        frac_d      = frac_q;
        ctr_d       = ctr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    frac_d  = cfg_frac;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (smp_hs) begin
                    acc_d = acc_sum;
                    tap_d = tap_q + TAP_W'(1);
                    if (tap_q == TAP_W'(CENTER_TAP)) begin
                        ctr_d = smp_data;
                    end
                    if (tap_q == TAP_W'(NTAPS - 1)) begin
                        // integer position bypasses the filter and returns the center sample
                        out_data_d  = (frac_q == '0) ? ctr_q : rounded;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (cfg_hs) begin
                        frac_d  = cfg_frac;
                        acc_d   = '0;
                        tap_d   = '0;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            frac_q      <= '0;
            ctr_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            frac_q      <= frac_d;
            ctr_q       <= ctr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_affine_interp_sched.sv
// tb/tb_affine_interp_sched.sv - self-checking bench for affine_interp_sched with a k*x stub bank
module tb_affine_interp_sched;
    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_frac;
    logic        smp_valid;
    logic        smp_ready;
    logic [7:0]  smp_data;
    logic [2:0]  mcm_tap;
    logic [3:0]  mcm_frac;
    logic signed [7:0] mcm_x;
    logic [15:0] mcm_y;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int tb_k   = 8;

    bit m_active = 0;
    bit m_done   = 0;
    int m_frac   = 0;
    int m_exp    = 0;
    int m_smp[$];

    affine_interp_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_frac  (cfg_frac),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_data  (smp_data),
        .mcm_tap   (mcm_tap),
        .mcm_frac  (mcm_frac),
        .mcm_x     (mcm_x),
        .mcm_y     (mcm_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    assign mcm_y = 16'(tb_k * int'(mcm_x));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int model_result();
        int sum;
        int r;
        logic signed [7:0] w;
        if (m_frac == 0) return m_smp[3];
        sum = 0;
        foreach (m_smp[i]) sum += tb_k * m_smp[i];
        r = (sum + 32) >>> 6;
`ifdef AFFINE_CLIP_EN
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
`else
        w = r[7:0];
        return int'(w);
`endif
    endfunction

    // Transaction-level model: checks outputs each cycle, then applies the handshakes of the coming edge
    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_done   = 0;
            m_frac   = 0;
            m_smp.delete();
        end
        chk("cfg_ready", int'(cfg_ready), (!m_active && (!m_done || out_ready)) ? 1 : 0);
        chk("smp_ready", int'(smp_ready), int'(m_active));
        chk("busy", int'(busy), (m_active || m_done) ? 1 : 0);
        chk("out_valid", int'(out_valid), int'(m_done));
        chk("mcm_tap", int'(mcm_tap), m_smp.size() % 8);
        chk("mcm_frac", int'(mcm_frac), m_frac);
        chk("mcm_x", int'(mcm_x), int'($signed(smp_data)));
        if (m_done) chk("out_data", int'($signed(out_data)), m_exp);
        if (rst_n) begin
            if (m_active && smp_valid) begin
                m_smp.push_back(int'($signed(smp_data)));
                if (m_smp.size() == 8) begin
                    m_exp    = model_result();
                    m_done   = 1;
                    m_active = 0;
                end
            end else if (m_done && out_ready) begin
                m_done = 0;
                if (cfg_valid) begin
                    m_frac   = int'(cfg_frac);
                    m_active = 1;
                    m_smp.delete();
                end
            end else if (!m_active && !m_done && cfg_valid) begin
                m_frac   = int'(cfg_frac);
                m_active = 1;
                m_smp.delete();
            end
        end
    end

    task automatic send_cfg(input int f);
        int n;
        cfg_valid = 1'b1;
        cfg_frac  = f[3:0];
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) chk("cfg_timeout", 0, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_smp(input int v);
        int n;
        smp_valid = 1'b1;
        smp_data  = v[7:0];
        n = 0;
        @(negedge clk);
        while (!smp_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!smp_ready) chk("smp_timeout", 0, 1);
        @(posedge clk);
        #1;
        smp_valid = 1'b0;
    endtask

    task automatic expect_result(input string name, input int exp);
        @(negedge clk);
        chk({name, "_valid"}, int'(out_valid), 1);
        chk({name, "_data"}, int'($signed(out_data)), exp);
        @(posedge clk);
        #1;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_frac  = 4'd0;
        smp_valid = 1'b0;
        smp_data  = 8'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_smp_ready", int'(smp_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        tb_k = 8;
        send_cfg(5);
        repeat (8) send_smp(10);
        expect_result("t1", 10);
        release_out();

        send_cfg(5);
        cfg_valid = 1'b1;
        cfg_frac  = 4'd15;
        repeat (8) send_smp(-3);
        cfg_valid = 1'b0;
        chk("t2_frac_ignored", int'(mcm_frac), 5);
        expect_result("t2", -3);
        release_out();

        tb_k = 16;
        send_cfg(9);
        repeat (8) send_smp(100);
`ifdef AFFINE_CLIP_EN
        expect_result("t3", 127);
`else
        expect_result("t3", -56);
`endif
        release_out();

        tb_k = 8;
        send_cfg(0);
        for (int i = 0; i < 8; i++) send_smp(i);
        expect_result("t4", 3);
        release_out();

        send_cfg(5);
        repeat (8) send_smp(10);
        expect_result("t5", 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_valid", int'(out_valid), 1);
            chk("t5_hold_data", int'($signed(out_data)), 10);
            chk("t5_hold_smp_ready", int'(smp_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cfg_valid = 1'b1;
        cfg_frac  = 4'd2;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("t5_b2b_acc", int'(smp_ready), 1);
        chk("t5_b2b_frac", int'(mcm_frac), 2);
        chk("t5_b2b_tap", int'(mcm_tap), 0);
        chk("t5_b2b_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        repeat (8) send_smp(7);
        expect_result("t5b", 7);
        release_out();

        send_cfg(5);
        repeat (4) send_smp(50);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_cfg_ready", int'(cfg_ready), 1);
        chk("t6_rst_tap", int'(mcm_tap), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_cfg(5);
        repeat (8) send_smp(1);
        expect_result("t6", 1);
        release_out();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
